// File: rtl/sd_dat_card_responder.sv
// rtl/sd_dat_card_responder.sv - card-side DAT0 responder: write receive/CRC status/busy, read block transmit
module sd_dat_card_responder #(
    parameter int BLOCK_WORDS = 4,
    parameter int BUSY_CYCLES = 8,
    parameter int NAC         = 2,
    parameter int NCRC        = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dat_i,
    output logic        dat_o,
    output logic        dat_oe_o,
    input  logic        wr_enable_i,
    input  logic        rd_start_i,
    input  logic [31:0] rd_word_i,
    output logic        rd_word_req_o,
    output logic [31:0] wr_word_o,
    output logic        wr_word_valid_o,
    output logic        busy_o,
    output logic        crc_err_o,
    output logic        block_done_o
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] W_DATA = 4'd1;
    localparam logic [3:0] W_CRC  = 4'd2;
    localparam logic [3:0] W_END  = 4'd3;
    localparam logic [3:0] W_GAP  = 4'd4;
    localparam logic [3:0] W_TOK  = 4'd5;
    localparam logic [3:0] W_BUSY = 4'd6;
    localparam logic [3:0] R_WAIT = 4'd7;
    localparam logic [3:0] R_DATA = 4'd8;
    localparam logic [3:0] R_CRC  = 4'd9;
    localparam logic [3:0] R_END  = 4'd10;

    localparam logic [7:0] LAST_W   = 8'(BLOCK_WORDS - 1);
    localparam logic [7:0] BUSY_C   = 8'(BUSY_CYCLES);
    localparam logic [7:0] NAC_C    = 8'(NAC);
    localparam logic [7:0] GAP_LAST = 8'(NCRC - 1);

    logic [3:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  word_q, word_d;
    logic [31:0] shreg_q, shreg_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_rx_q, crc_rx_d;
    logic        ok_q, ok_d;
    logic [31:0] wr_word_q, wr_word_d;
    logic        wr_word_valid_q, wr_word_valid_d;
    logic        crc_err_q, crc_err_d;
    logic        block_done_q, block_done_d;
    logic [4:0]  tok;

    function automatic logic [15:0] crc16_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        word_d          = word_q;
        shreg_d         = shreg_q;
        crc_d           = crc_q;
        crc_rx_d        = crc_rx_q;
        ok_d            = ok_q;
        wr_word_d       = wr_word_q;
        wr_word_valid_d = 1'b0;
        crc_err_d       = 1'b0;
        block_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // a host start bit takes priority over a simultaneous read request
                if (wr_enable_i && !dat_i) begin
                    state_d = W_DATA;
                    cnt_d   = 8'd0;
                    word_d  = 8'd0;
                    crc_d   = 16'h0000;
                end else if (rd_start_i) begin
                    state_d = R_WAIT;
                    cnt_d   = 8'd0;
                    word_d  = 8'd0;
                    crc_d   = 16'h0000;
                end
            end
            W_DATA: begin
                shreg_d = {shreg_q[30:0], dat_i};
                crc_d   = crc16_bit(crc_q, dat_i);
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'd31) begin
                    wr_word_d       = {shreg_q[30:0], dat_i};
                    wr_word_valid_d = 1'b1;
                    cnt_d           = 8'd0;
                    word_d          = word_q + 8'd1;
                    if (word_q == LAST_W) state_d = W_CRC;
                end
            end
            W_CRC: begin
                crc_rx_d = {crc_rx_q[14:0], dat_i};
                cnt_d    = cnt_q + 8'd1;
                if (cnt_q == 8'd15) begin
                    state_d = W_END;
                    cnt_d   = 8'd0;
                end
            end
            W_END: begin
                ok_d      = (crc_rx_q == crc_q) && dat_i;
                crc_err_d = !((crc_rx_q == crc_q) && dat_i);
                state_d   = W_GAP;
                cnt_d     = 8'd0;
            end
            W_GAP: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == GAP_LAST) begin
                    state_d = W_TOK;
                    cnt_d   = 8'd0;
                end
            end
            W_TOK: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd4) begin
                    cnt_d = 8'd0;
                    if (ok_q) begin
                        state_d = W_BUSY;
                    end else begin
                        state_d      = IDLE;
                        block_done_d = 1'b1;
                    end
                end
            end
            W_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == BUSY_C) begin
                    state_d      = IDLE;
                    block_done_d = 1'b1;
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == NAC_C) begin
                    shreg_d = rd_word_i;
                    state_d = R_DATA;
                    cnt_d   = 8'd0;
                end
            end
            R_DATA: begin
                crc_d   = crc16_bit(crc_q, shreg_q[31]);
                shreg_d = {shreg_q[30:0], 1'b0};
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'd31) begin
                    cnt_d = 8'd0;
                    if (word_q == LAST_W) begin
                        state_d = R_CRC;
                    end else begin
                        shreg_d = rd_word_i;
                        word_d  = word_q + 8'd1;
                    end
                end
            end
            R_CRC: begin
                crc_d = {crc_q[14:0], 1'b0};
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd15) begin
                    state_d = R_END;
                    cnt_d   = 8'd0;
                end
            end
            R_END: begin
                state_d      = IDLE;
                block_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tok           = {1'b0, ok_q ? 3'b010 : 3'b101, 1'b1};
        dat_o         = 1'b1;
        dat_oe_o      = 1'b0;
        busy_o        = 1'b0;
        rd_word_req_o = 1'b0;
        case (state_q)
            W_TOK: begin
                dat_oe_o = 1'b1;
                dat_o    = tok[3'd4 - cnt_q[2:0]];
            end
            W_BUSY: begin
                dat_oe_o = 1'b1;
                busy_o   = (cnt_q != BUSY_C);
                dat_o    = (cnt_q == BUSY_C);
            end
            R_WAIT: begin
                if (cnt_q == NAC_C) begin
                    dat_oe_o      = 1'b1;
                    dat_o         = 1'b0;
                    rd_word_req_o = 1'b1;
                end
            end
            R_DATA: begin
                dat_oe_o      = 1'b1;
                dat_o         = shreg_q[31];
                rd_word_req_o = (cnt_q == 8'd31) && (word_q != LAST_W);
            end
            R_CRC: begin
                dat_oe_o = 1'b1;
                dat_o    = crc_q[15];
            end
            R_END: begin
                dat_oe_o = 1'b1;
                dat_o    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            word_q          <= 8'd0;
            shreg_q         <= 32'd0;
            crc_q           <= 16'h0000;
            crc_rx_q        <= 16'h0000;
            ok_q            <= 1'b0;
            wr_word_q       <= 32'd0;
            wr_word_valid_q <= 1'b0;
            crc_err_q       <= 1'b0;
            block_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            word_q          <= word_d;
            shreg_q         <= shreg_d;
            crc_q           <= crc_d;
            crc_rx_q        <= crc_rx_d;
            ok_q            <= ok_d;
            wr_word_q       <= wr_word_d;
            wr_word_valid_q <= wr_word_valid_d;
            crc_err_q       <= crc_err_d;
            block_done_q    <= block_done_d;
        end
    end

    assign wr_word_o       = wr_word_q;
    assign wr_word_valid_o = wr_word_valid_q;
    assign crc_err_o       = crc_err_q;
    assign block_done_o    = block_done_q;

endmodule

// File: tb/tb_sd_dat_card_responder.sv
// tb/tb_sd_dat_card_responder.sv - bench for sd_dat_card_responder (one-word and four-word block instances)
module tb_sd_dat_card_responder;

    typedef struct {
        logic            sel;
        int              n;
        logic [3:0][31:0] w;
        logic            is_read;
        logic            flip;
        logic            end_bit;
        logic            also_rd;
        int              mode;
        logic            exp_ok;
    } vec_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni;
    logic        sel;
    logic        h_dat, h_wr_en, h_rd_start;
    logic [31:0] h_rd_word;

    logic [1:0]  in_dat, in_wr, in_rd;
    logic [1:0]  o_dat, o_oe, o_req, o_wv, o_busy, o_err, o_done;
    logic [31:0] o_ww [2];

    assign in_dat[0] = (sel == 1'b0) ? h_dat      : 1'b1;
    assign in_dat[1] = (sel == 1'b1) ? h_dat      : 1'b1;
    assign in_wr[0]  = (sel == 1'b0) ? h_wr_en    : 1'b0;
    assign in_wr[1]  = (sel == 1'b1) ? h_wr_en    : 1'b0;
    assign in_rd[0]  = (sel == 1'b0) ? h_rd_start : 1'b0;
    assign in_rd[1]  = (sel == 1'b1) ? h_rd_start : 1'b0;

    sd_dat_card_responder #(.BLOCK_WORDS(1), .BUSY_CYCLES(8), .NAC(2), .NCRC(2)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .dat_i(in_dat[0]), .dat_o(o_dat[0]), .dat_oe_o(o_oe[0]),
        .wr_enable_i(in_wr[0]), .rd_start_i(in_rd[0]), .rd_word_i(h_rd_word),
        .rd_word_req_o(o_req[0]), .wr_word_o(o_ww[0]), .wr_word_valid_o(o_wv[0]),
        .busy_o(o_busy[0]), .crc_err_o(o_err[0]), .block_done_o(o_done[0])
    );

    sd_dat_card_responder #(.BLOCK_WORDS(4), .BUSY_CYCLES(8), .NAC(2), .NCRC(2)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .dat_i(in_dat[1]), .dat_o(o_dat[1]), .dat_oe_o(o_oe[1]),
        .wr_enable_i(in_wr[1]), .rd_start_i(in_rd[1]), .rd_word_i(h_rd_word),
        .rd_word_req_o(o_req[1]), .wr_word_o(o_ww[1]), .wr_word_valid_o(o_wv[1]),
        .busy_o(o_busy[1]), .crc_err_o(o_err[1]), .block_done_o(o_done[1])
    );

    logic        cur_dat, cur_oe, cur_req, cur_busy, cur_err, cur_done, cur_wv;
    logic [31:0] cur_ww;
    assign cur_dat  = o_dat[sel];
    assign cur_oe   = o_oe[sel];
    assign cur_req  = o_req[sel];
    assign cur_busy = o_busy[sel];
    assign cur_err  = o_err[sel];
    assign cur_done = o_done[sel];
    assign cur_wv   = o_wv[sel];
    assign cur_ww   = o_ww[sel];

    int req_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};
    logic [31:0] wq0[$];
    logic [31:0] wq1[$];

    always @(negedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (o_req[k]) req_cnt[k]++;
            if (o_err[k]) err_cnt[k]++;
        end
        if (o_wv[0]) wq0.push_back(o_ww[0]);
        if (o_wv[1]) wq1.push_back(o_ww[1]);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // remainder of data*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_model(input logic [3:0][31:0] w, input int n);
        logic [16:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            for (int b = 31; b >= 0; b--) begin
                r = {r[15:0], w[k][b]};
                if (r[16]) r = r ^ 17'h11021;
            end
        for (int b = 0; b < 16; b++) begin
            r = {r[15:0], 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    task automatic do_write(input vec_t v);
        logic [15:0] crc;
        logic [4:0]  tok;
        int req0, err0, qs, gap, nb, lowbad;
        logic [31:0] got;
        crc = crc_model(v.w, v.n);
        if (v.flip) crc[7] = ~crc[7];
        req0 = req_cnt[sel];
        err0 = err_cnt[sel];
        qs = sel ? wq1.size() : wq0.size();
        h_wr_en = 1'b1; h_dat = 1'b0; h_rd_start = v.also_rd;
        tick;
        h_rd_start = 1'b0;
        for (int k = 0; k < v.n; k++)
            for (int b = 31; b >= 0; b--) begin h_dat = v.w[k][b]; tick; end
        for (int b = 15; b >= 0; b--) begin h_dat = crc[b]; tick; end
        h_dat = v.end_bit;
        tick;
        h_dat = 1'b1; h_wr_en = 1'b0;
        chk("wr_crc_err_pulse", cur_err, !v.exp_ok);
        chk("wr_word_count", (sel ? wq1.size() : wq0.size()) - qs, v.n);
        for (int k = 0; k < v.n; k++) begin
            got = sel ? wq1[qs + k] : wq0[qs + k];
            chk("wr_word", got, v.w[k]);
        end
        gap = 0;
        while (!cur_oe && gap < 20) begin gap++; tick; end
        chk("tok_gap", gap, 2);
        for (int i = 4; i >= 0; i--) begin
            tok[i] = cur_oe ? cur_dat : 1'bx;
            tick;
        end
        chk("token", tok, v.exp_ok ? 5'b00101 : 5'b01011);
        if (v.exp_ok) begin
            nb = 0; lowbad = 0;
            while (cur_busy && nb < 50) begin
                if (cur_dat !== 1'b0 || cur_oe !== 1'b1) lowbad++;
                if (nb == 3 && v.mode == 1) h_rd_start = 1'b1;
                if (nb == 3 && v.mode == 2) begin
                    rst_ni = 1'b0;
                    #1;
                    chk("rst_busy_oe_dat", {cur_oe, cur_dat, cur_busy}, 3'b010);
                    chk("rst_busy_wr_word", cur_ww, 32'd0);
                    rst_ni = 1'b1;
                    tick;
                    chk("rst_busy_idle", {cur_oe, cur_busy}, 2'b00);
                    return;
                end
                nb++;
                tick;
                h_rd_start = 1'b0;
            end
            chk("busy_len", nb, 8);
            chk("busy_low", lowbad, 0);
            chk("busy_release", {cur_oe, cur_dat}, 2'b11);
            tick;
        end
        chk("wr_done", {cur_done, cur_oe, cur_busy}, 3'b100);
        tick;
        chk("wr_done_pulse", cur_done, 1'b0);
        for (int i = 0; i < 5; i++) tick;
        chk("wr_no_read", req_cnt[sel] - req0, 0);
        chk("wr_idle_oe", cur_oe, 1'b0);
        chk("wr_err_count", err_cnt[sel] - err0, v.exp_ok ? 0 : 1);
    endtask

    task automatic do_read(input vec_t v);
        logic [3:0][31:0] got;
        logic [15:0]      got_crc;
        int req0, gap, nreq, reqbad, oebad;
        logic exp_req;
        got = '0;
        req0 = req_cnt[sel];
        nreq = 0; reqbad = 0; oebad = 0;
        h_rd_word = v.w[0]; h_rd_start = 1'b1;
        tick;
        h_rd_start = 1'b0;
        gap = 0;
        while (!cur_oe && gap < 20) begin gap++; tick; end
        chk("rd_nac", gap, 2);
        chk("rd_start_bit_req", {cur_dat, cur_req}, 2'b01);
        if (cur_req) nreq++;
        tick;
        h_rd_word = v.w[nreq > 3 ? 3 : nreq];
        for (int i = 0; i < 32 * v.n; i++) begin
            exp_req = ((i % 32) == 31) && ((i / 32) < v.n - 1);
            if (cur_req !== exp_req) reqbad++;
            if (cur_oe !== 1'b1) oebad++;
            got[i / 32][31 - (i % 32)] = cur_dat;
            if (cur_req) nreq++;
            tick;
            h_rd_word = v.w[nreq > 3 ? 3 : nreq];
        end
        for (int j = 15; j >= 0; j--) begin
            if (cur_oe !== 1'b1) oebad++;
            got_crc[j] = cur_dat;
            tick;
        end
        chk("rd_end_bit", {cur_oe, cur_dat}, 2'b11);
        tick;
        chk("rd_done", {cur_done, cur_oe}, 2'b10);
        for (int k = 0; k < v.n; k++) chk("rd_word", got[k], v.w[k]);
        chk("rd_crc", got_crc, crc_model(v.w, v.n));
        chk("rd_req_timing", reqbad, 0);
        chk("rd_oe_held", oebad, 0);
        chk("rd_req_count", req_cnt[sel] - req0, v.n);
        tick;
    endtask

    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1, {32'd0, 32'd0, 32'd0, 32'hC0000003}, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1};
        tbl[1] = '{1'b0, 1, {32'd0, 32'd0, 32'd0, 32'hC0000003}, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        tbl[2] = '{1'b0, 1, {32'd0, 32'd0, 32'd0, 32'hC0000003}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[3] = '{1'b0, 1, {32'd0, 32'd0, 32'd0, 32'hC000E000}, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1};
        tbl[4] = '{1'b1, 4, {32'd4, 32'd3, 32'd2, 32'd1},         1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1};
        tbl[5] = '{1'b1, 4, {32'd4, 32'd3, 32'd2, 32'd1},         1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1};
        tbl[6] = '{1'b0, 1, {32'd0, 32'd0, 32'd0, 32'hA5A5F00F}, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1};
        tbl[7] = '{1'b0, 1, {32'd0, 32'd0, 32'd0, 32'h12345678}, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1};

        rst_ni = 1'b0; sel = 1'b0;
        h_dat = 1'b1; h_wr_en = 1'b0; h_rd_start = 1'b0; h_rd_word = 32'd0;
        tick; tick;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_lines", {cur_oe, cur_dat, cur_busy}, 3'b010);
            chk("reset_pulses", {cur_req, cur_wv, cur_err, cur_done}, 4'b0000);
            chk("reset_wr_word", cur_ww, 32'd0);
        end
        rst_ni = 1'b1;
        tick; tick;

        for (int i = 0; i < 8; i++) begin
            sel = tbl[i].sel;
            if (tbl[i].is_read) do_read(tbl[i]);
            else do_write(tbl[i]);
            tick; tick;
        end

        // reset in the middle of a four-word read
        sel = 1'b1;
        h_rd_word = 32'hFFFF0000; h_rd_start = 1'b1;
        tick;
        h_rd_start = 1'b0;
        for (int i = 0; i < 13; i++) tick;
        chk("pre_rst_rd_oe", cur_oe, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("rst_rd_lines", {cur_oe, cur_dat, cur_req}, 3'b010);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        chk("rst_rd_idle", {cur_oe, cur_done}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
